rv_byte_packer: RTL and testbench
=================================

# rv_byte_packer

Byte-to-word packer on the srdy/rrdy (valid/ready) stream fabric. Consumes the 8-bit stream produced by the byte elastic buffer stage and packs NBYTES consecutive bytes, little-endian, into one wide word for the downstream word-wide datapath. An optional `in_last` marker closes a partial word early, so packet boundaries are preserved. Two internal registers (accumulator and output) decouple the input and output handshakes. `in_rrdy` has no combinational path from `out_rrdy`.

## Interface
- `NBYTES`, default 4: bytes per output word; must be ≥ 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_srdy`  input  1  input byte valid.
- `in_data`  input  8  input byte.
- `in_last`  input  1  qualifies `in_data` as the final byte of a packet; sampled only on an accepted transfer.
- `in_rrdy`  output  1  packer can accept a byte.
- `out_srdy`  output  1  output word valid.
- `out_data`  output  8*NBYTES  packed word; byte k occupies bits [8k+7:8k].
- `out_cnt`  output  $clog2(NBYTES)+1  number of valid bytes in `out_data`, from 1 to NBYTES.
- `out_last`  output  1  word ends a packet.
- `out_rrdy`  input  1  downstream accepts the word.

## Operation
- **Transfer rules**
  - An input transfer occurs when `in_srdy && in_rrdy`.
  - An output transfer occurs when `out_srdy && out_rrdy`.
- **Accumulator** holds `acc_data`, `acc_cnt` (0..NBYTES-1 bytes held), `acc_last` and a `pend` flag.
- **Output register** holds `out_srdy`, `out_data`, `out_cnt` and `out_last`.
- `in_rrdy = !pend`. This is a pure function of registered state.
- **Accepted byte:** written into lane `acc_cnt`. The word completes when `acc_cnt == NBYTES-1` or `in_last == 1`.
  - If not complete: `acc_cnt` increments.
  - If complete and the output slot is free this cycle (`!out_srdy || out_rrdy`): the word, including the new byte, is loaded into the output register at the same edge. `out_cnt` is set to `acc_cnt+1` and `out_last` to `in_last`. The accumulator clears (data 0, `acc_cnt` 0).
  - If complete and the slot is not free: the accumulator keeps the word and sets `pend=1`. `acc_last` captures `in_last`.
- **Pending word:** when `pend=1` and the output slot frees (`!out_srdy || out_rrdy`), the accumulator moves to the output register at that edge. The accumulator then clears and `pend` returns to 0.
- **Output consumed, nothing loaded:** `out_srdy` goes to 0. `out_data`, `out_cnt` and `out_last` keep their values; they are don't-care while `out_srdy=0`.
- **Unused lanes** (index ≥ `out_cnt`) are always 0 in `out_data`.
- **Stability:** while `out_srdy && !out_rrdy`, `out_data`, `out_cnt` and `out_last` are held stable.
- **Ordering:** words leave in the order completed. No byte is dropped or duplicated.
- `in_last` on an idle accumulator (`acc_cnt=0`) produces a 1-byte word.
- `in_last` on lane NBYTES-1 produces a full word with `out_last=1`.
- **Reset:**
  - Outputs: `out_srdy=0`, `out_data=0`, `out_cnt=0`, `out_last=0`, `in_rrdy=1`.
  - Internal state: accumulator cleared, `pend=0`.
  - Reset mid-word discards any partial or pending word. The next accepted byte goes to lane 0.

## Timing
- **Latency:** the word is valid in the cycle after the edge that accepts its completing byte, provided the slot is free. Otherwise it is valid in the cycle after the slot frees.
- **Throughput:** 1 byte/cycle on the input. One word per NBYTES cycles is sustained with `out_rrdy=1`, with no input bubbles.
- **Backpressure:**
  - Bytes of the next word keep being accepted while the output holds a word.
  - `in_rrdy` drops in the cycle after the edge that completes a second word while the output is still occupied.
- **Release from backpressure:** when `out_rrdy` rises while `pend=1`, the pending word moves to the output at that edge. `in_rrdy` returns to 1 in the following cycle, giving one input bubble.
- **Simultaneous output transfer and new word completion:** the new word loads at the same edge and `out_srdy` stays 1, with no output bubble.

## Test plan
- **Full word, no backpressure.** NBYTES=4, `out_rrdy=1`. Send 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required: the cycle after the 4th byte, `out_srdy=1`, `out_data=0x44332211`, `out_cnt=4`, `out_last=0`, held for exactly 1 cycle.
- **Short packet.** Send 0xAA, then 0xBB with `in_last=1`.
  - Required: `out_data=0x0000BBAA`, `out_cnt=2`, `out_last=1`. The next byte 0x01 lands in lane 0.
- **Single-byte packet.** Send 0x5A with `in_last=1` while idle.
  - Required: `out_data=0x0000005A`, `out_cnt=1`, `out_last=1`.
- **Backpressure.** Hold `out_rrdy=0` and stream bytes 0x01..0x08 with `in_srdy=1`.
  - Required: `out_data=0x04030201` is held stable. `in_rrdy=0` from the cycle after byte 0x08 is accepted.
  - Then raise `out_rrdy`. Required: words 0x04030201 then 0x08070605 in consecutive cycles, and `in_rrdy=1` one cycle after the second word loads.
- **Reset mid-word.** Send 0x10, 0x20, then assert `reset` for 1 cycle. Then send 0xA1, 0xA2, 0xA3, 0xA4.
  - Required during reset: all outputs at reset values.
  - Required after: `out_data=0xA4A3A2A1`, `out_cnt=4`, with no trace of 0x10 or 0x20.
- **Random soak.** Randomise `in_srdy`, `out_rrdy` and `in_last` (10% probability), and compare against a reference queue model.
  - Required: byte order and word boundaries match, and `out_data` is stable whenever `out_srdy && !out_rrdy`.

Source files
------------

// File: rtl/rv_byte_packer.sv
// Byte-to-word packer on a srdy/rrdy stream: packs NBYTES little-endian bytes per word,
// with in_last closing a partial word early. Accumulator and output register decouple handshakes.
module rv_byte_packer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_srdy,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     in_rrdy,
    output logic                     out_srdy,
    output logic [8*NBYTES-1:0]      out_data,
    output logic [$clog2(NBYTES):0]  out_cnt,
    output logic                     out_last,
    input  logic                     out_rrdy
);

    localparam int unsigned CW = $clog2(NBYTES) + 1;
    localparam int unsigned DW = 8 * NBYTES;

    logic [DW-1:0] r_acc_data;
    logic [CW-1:0] r_acc_cnt;
    logic          r_acc_last;
    logic          r_pend;
    logic          r_out_srdy;
    logic [DW-1:0] r_out_data;
    logic [CW-1:0] r_out_cnt;
    logic          r_out_last;

    logic          w_slot_free;
    logic          w_in_xfer;
    logic          w_complete;
    logic [DW-1:0] w_merged;
    logic [CW-1:0] w_cnt_inc;

    always_comb begin
        w_slot_free = !r_out_srdy || out_rrdy;
        w_in_xfer   = in_srdy && !r_pend;
        w_complete  = w_in_xfer && (in_last || (r_acc_cnt == CW'(NBYTES - 1)));
        w_cnt_inc   = r_acc_cnt + CW'(1);
        w_merged    = r_acc_data;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_acc_cnt == CW'(k)) begin
                w_merged[8*k +: 8] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_data <= '0;
            r_acc_cnt  <= '0;
            r_acc_last <= 1'b0;
            r_pend     <= 1'b0;
            r_out_srdy <= 1'b0;
            r_out_data <= '0;
            r_out_cnt  <= '0;
            r_out_last <= 1'b0;
        end else if (r_pend && w_slot_free) begin
            // While pending, r_acc_cnt already holds the full byte count of the word.
            r_out_srdy <= 1'b1;
            r_out_data <= r_acc_data;
            r_out_cnt  <= r_acc_cnt;
            r_out_last <= r_acc_last;
            r_acc_data <= '0;
            r_acc_cnt  <= '0;
            r_acc_last <= 1'b0;
            r_pend     <= 1'b0;
        end else if (w_complete && w_slot_free) begin
            r_out_srdy <= 1'b1;
            r_out_data <= w_merged;
            r_out_cnt  <= w_cnt_inc;
            r_out_last <= in_last;
            r_acc_data <= '0;
            r_acc_cnt  <= '0;
            r_acc_last <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_acc_data <= w_merged;
                r_acc_cnt  <= w_cnt_inc;
                if (w_complete) begin
                    r_pend     <= 1'b1;
                    r_acc_last <= in_last;
                end
            end
            if (out_rrdy) begin
                r_out_srdy <= 1'b0;
            end
        end
    end

    assign in_rrdy  = !r_pend;
    assign out_srdy = r_out_srdy;
    assign out_data = r_out_data;
    assign out_cnt  = r_out_cnt;
    assign out_last = r_out_last;

endmodule

// File: tb/tb_rv_byte_packer.sv
// Self-checking bench for rv_byte_packer (NBYTES=4): directed scenarios plus a
// scoreboard monitor comparing every output word against a byte-level reference model.
module tb_rv_byte_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_srdy = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_rrdy;
    logic        out_srdy;
    logic [31:0] out_data;
    logic [2:0]  out_cnt;
    logic        out_last;
    logic        out_rrdy = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_data[$];
    logic [2:0]  q_cnt[$];
    logic        q_last[$];

    rv_byte_packer #(.NBYTES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_srdy  (in_srdy),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_rrdy  (in_rrdy),
        .out_srdy (out_srdy),
        .out_data (out_data),
        .out_cnt  (out_cnt),
        .out_last (out_last),
        .out_rrdy (out_rrdy)
    );

    always #5 clk = ~clk;

    // Scoreboard: reference model packs accepted bytes, pops on each output transfer.
    initial begin : monitor
        logic [31:0] m_word;
        int          m_cnt;
        logic        prev_hold;
        logic [31:0] prev_data;
        logic [2:0]  prev_cnt;
        logic        prev_last;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_last;
        m_word = '0;
        m_cnt = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_cnt = '0;
        prev_last = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                q_data.delete();
                q_cnt.delete();
                q_last.delete();
                m_word = '0;
                m_cnt = 0;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    n_tests++;
                    if (out_data !== prev_data || out_cnt !== prev_cnt || out_last !== prev_last) begin
                        n_fail++;
                        $display("FAIL stable: got %h/%0d/%0d, required %h/%0d/%0d",
                                 out_data, out_cnt, out_last, prev_data, prev_cnt, prev_last);
                    end
                end
                if (out_srdy && out_rrdy) begin
                    n_tests++;
                    if (q_data.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got word %h, required none", out_data);
                    end else begin
                        e_data = q_data.pop_front();
                        e_cnt  = q_cnt.pop_front();
                        e_last = q_last.pop_front();
                        if (out_data !== e_data || out_cnt !== e_cnt || out_last !== e_last) begin
                            n_fail++;
                            $display("FAIL sb_word: got %h/%0d/%0d, required %h/%0d/%0d",
                                     out_data, out_cnt, out_last, e_data, e_cnt, e_last);
                        end
                    end
                end
                if (in_srdy && in_rrdy) begin
                    m_word[8*m_cnt +: 8] = in_data;
                    m_cnt++;
                    if (m_cnt == 4 || in_last) begin
                        q_data.push_back(m_word);
                        q_cnt.push_back(3'(m_cnt));
                        q_last.push_back(in_last);
                        m_word = '0;
                        m_cnt = 0;
                    end
                end
                prev_hold = out_srdy && !out_rrdy;
                prev_data = out_data;
                prev_cnt  = out_cnt;
                prev_last = out_last;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            in_srdy = 1'b1;
            in_data = d;
            in_last = l;
            if (in_rrdy) done = 1'b1;
            @(posedge clk);
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted, required acceptance", d);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_srdy = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (out_srdy !== 1'b0 || out_data !== 32'h0 || out_cnt !== 3'd0 || out_last !== 1'b0
            || in_rrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: got srdy=%b data=%h cnt=%0d last=%b rrdy=%b, required 0/0/0/0/1",
                     out_srdy, out_data, out_cnt, out_last, in_rrdy);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_word();
        logic [7:0] bytes_q[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_rrdy = 1'b1;
        foreach (bytes_q[i]) send_byte(bytes_q[i], 1'b0);
        #1;
        n_tests++;
        if (out_srdy !== 1'b1 || out_data !== 32'h44332211 || out_cnt !== 3'd4 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL full_word: got srdy=%b %h/%0d/%b, required 1 44332211/4/0",
                     out_srdy, out_data, out_cnt, out_last);
        end
        go_idle();
        @(posedge clk);
        #1;
        n_tests++;
        if (out_srdy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_word_one_cycle: got srdy=%b, required 0", out_srdy);
        end
    endtask

    task automatic test_short_packet();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        #1;
        n_tests++;
        if (out_srdy !== 1'b1 || out_data !== 32'h0000BBAA || out_cnt !== 3'd2 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL short_packet: got srdy=%b %h/%0d/%b, required 1 0000bbaa/2/1",
                     out_srdy, out_data, out_cnt, out_last);
        end
        send_byte(8'h01, 1'b1);
        #1;
        n_tests++;
        if (out_data !== 32'h00000001 || out_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL short_next_lane0: got %h/%0d, required 00000001/1", out_data, out_cnt);
        end
        go_idle();
    endtask

    task automatic test_single_byte();
        @(negedge clk);
        send_byte(8'h5A, 1'b1);
        #1;
        n_tests++;
        if (out_srdy !== 1'b1 || out_data !== 32'h0000005A || out_cnt !== 3'd1 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL single_byte: got srdy=%b %h/%0d/%b, required 1 0000005a/1/1",
                     out_srdy, out_data, out_cnt, out_last);
        end
        go_idle();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_rrdy = 1'b0;
        for (int b = 1; b <= 8; b++) begin
            send_byte(8'(b), 1'b0);
            #1;
            if (b >= 4) begin
                n_tests++;
                if (out_srdy !== 1'b1 || out_data !== 32'h04030201 || in_rrdy !== (b < 8)) begin
                    n_fail++;
                    $display("FAIL bp_hold_b%0d: got srdy=%b data=%h rrdy=%b, required 1 04030201 %b",
                             b, out_srdy, out_data, in_rrdy, b < 8);
                end
            end
        end
        @(negedge clk);
        in_srdy = 1'b0;
        out_rrdy = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (out_srdy !== 1'b1 || out_data !== 32'h08070605 || in_rrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got srdy=%b data=%h rrdy=%b, required 1 08070605 1",
                     out_srdy, out_data, in_rrdy);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (out_srdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drained: got srdy=%b, required 0", out_srdy);
        end
    endtask

    task automatic test_reset_mid_word();
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        @(negedge clk);
        in_srdy = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (out_srdy !== 1'b0 || out_data !== 32'h0 || out_cnt !== 3'd0 || out_last !== 1'b0
            || in_rrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_values: got srdy=%b data=%h cnt=%0d last=%b rrdy=%b, required 0/0/0/0/1",
                     out_srdy, out_data, out_cnt, out_last, in_rrdy);
        end
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        #1;
        n_tests++;
        if (out_srdy !== 1'b1 || out_data !== 32'hA4A3A2A1 || out_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL after_reset_word: got srdy=%b %h/%0d, required 1 a4a3a2a1/4",
                     out_srdy, out_data, out_cnt);
        end
        go_idle();
    endtask

    task automatic test_random_soak();
        int waited = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_srdy  = ($urandom_range(0, 1) == 1);
            in_data  = 8'($urandom);
            in_last  = ($urandom_range(0, 9) == 0);
            out_rrdy = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_srdy = 1'b0;
        out_rrdy = 1'b1;
        send_byte(8'hEE, 1'b1);
        go_idle();
        while (q_data.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        #1;
        n_tests++;
        if (q_data.size() != 0 || out_srdy !== 1'b0) begin
            n_fail++;
            $display("FAIL soak_drain: got %0d words outstanding srdy=%b, required 0 and 0",
                     q_data.size(), out_srdy);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_packet();
        test_single_byte();
        test_backpressure();
        test_reset_mid_word();
        test_random_soak();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
